// File: rtl/pingpong_word_loader_if.sv
// pingpong_word_loader_if: nibble stream in, bank words and select out; LOADER_PARITY_EN adds in_par/par_err
interface pingpong_word_loader_if #(
    parameter int WORD_W = 20,
    parameter int NIB_W  = 4
);
    logic              in_valid;
    logic [NIB_W-1:0]  in_data;
    logic              in_ready;
    logic              hold;
    logic [WORD_W-1:0] K0;
    logic [WORD_W-1:0] K1;
    logic              S;
    logic              word_done;
`ifdef LOADER_PARITY_EN
    logic              in_par;
    logic              par_err;

    modport master (output in_valid, in_data, hold, in_par,
                    input in_ready, K0, K1, S, word_done, par_err);
    modport slave (input in_valid, in_data, hold, in_par,
                   output in_ready, K0, K1, S, word_done, par_err);
`else
    modport master (output in_valid, in_data, hold,
                    input in_ready, K0, K1, S, word_done);
    modport slave (input in_valid, in_data, hold,
                   output in_ready, K0, K1, S, word_done);
`endif
endinterface

// File: rtl/pingpong_word_loader.sv
// pingpong_word_loader: assembles nibbles into words, loads the inactive bank, then swaps S; LOADER_PARITY_EN adds even-parity check
module pingpong_word_loader #(
    parameter int WORD_W = 20,
    parameter int NIB_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    pingpong_word_loader_if.slave bus
);
    localparam int BEATS = WORD_W / NIB_W;
    localparam int CNT_W = $clog2(BEATS);

    typedef enum logic {COLLECT, PEND} state_t;

    state_t                    state, state_n;
    logic [CNT_W-1:0]          cnt, cnt_n;
    logic [WORD_W-NIB_W-1:0]   shreg, shreg_n;
    logic [WORD_W-1:0]         k0_n, k1_n, word;
    logic                      s_n, done_n, commit, perr_n;

    assign bus.in_ready = !rst && state == COLLECT;
    assign word = {shreg, bus.in_data};
`ifdef LOADER_PARITY_EN
    assign commit = ~(^word ^ bus.in_par);
`else
    assign commit = 1'b1;
`endif

    // next-state: shift beats, load the inactive bank on the last beat, swap once hold is released
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        shreg_n = shreg;
        k0_n    = bus.K0;
        k1_n    = bus.K1;
        s_n     = bus.S;
        done_n  = 1'b0;
        perr_n  = 1'b0;
        if (state == COLLECT && bus.in_valid) begin
            if (cnt != CNT_W'(BEATS - 1)) begin
                shreg_n = {shreg[WORD_W-2*NIB_W-1:0], bus.in_data};
                cnt_n   = cnt + CNT_W'(1);
            end else begin
                cnt_n   = '0;
                perr_n  = !commit;
                state_n = commit ? PEND : COLLECT;
                k0_n    = (commit && bus.S)  ? word : bus.K0;
                k1_n    = (commit && !bus.S) ? word : bus.K1;
            end
        end else if (state == PEND && !bus.hold) begin
            s_n     = !bus.S;
            done_n  = 1'b1;
            state_n = COLLECT;
        end
    end

    // state and output registers, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            cnt           <= '0;
            shreg         <= '0;
            bus.K0        <= '0;
            bus.K1        <= '0;
            bus.S         <= 1'b0;
            bus.word_done <= 1'b0;
`ifdef LOADER_PARITY_EN
            bus.par_err   <= 1'b0;
`endif
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            shreg         <= shreg_n;
            bus.K0        <= k0_n;
            bus.K1        <= k1_n;
            bus.S         <= s_n;
            bus.word_done <= done_n;
`ifdef LOADER_PARITY_EN
            bus.par_err   <= perr_n;
`endif
        end
    end

`ifndef LOADER_PARITY_EN
    logic unused_perr;
    assign unused_perr = perr_n;
`endif
endmodule

// File: tb/tb_pingpong_word_loader.sv
// tb_pingpong_word_loader: directed and random nibble traffic checked against a word-level reference model
module tb_pingpong_word_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    pingpong_word_loader_if bus ();
    pingpong_word_loader dut (.clk(clk), .rst(rst), .bus(bus));

    // reference model: nibbles gathered in a queue, word built arithmetically
    int unsigned nibs[$];
    int unsigned bank[2];
    int unsigned m_s, m_done, m_perr;
    bit pend;
    logic m_par;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input logic v, input logic [3:0] d, input logic h);
        int unsigned w;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.hold     = h;
`ifdef LOADER_PARITY_EN
        bus.in_par   = m_par;
`endif
        #1;
        chk("in_ready", 32'(bus.in_ready), 32'(!rst && !pend));
        @(posedge clk);
        m_done = 0;
        m_perr = 0;
        if (rst) begin
            nibs.delete();
            bank[0] = 0;
            bank[1] = 0;
            m_s = 0;
            pend = 0;
        end else if (pend) begin
            if (!h) begin
                m_s = 1 - m_s;
                m_done = 1;
                pend = 0;
            end
        end else if (v) begin
            nibs.push_back(int'(d));
            if (nibs.size() == 5) begin
                w = 0;
                foreach (nibs[i]) w = w * 16 + nibs[i];
                nibs.delete();
`ifdef LOADER_PARITY_EN
                if (($countones(w) + int'(m_par)) % 2 != 0) m_perr = 1;
`endif
                if (m_perr == 0) begin
                    bank[1 - m_s] = w;
                    pend = 1;
                end
            end
        end
        @(negedge clk);
        chk("K0", 32'(bus.K0), bank[0]);
        chk("K1", 32'(bus.K1), bank[1]);
        chk("S", 32'(bus.S), m_s);
        chk("word_done", 32'(bus.word_done), m_done);
`ifdef LOADER_PARITY_EN
        chk("par_err", 32'(bus.par_err), m_perr);
`endif
    endtask

    task automatic send_word(input logic [19:0] w, input int hold_cycles);
        m_par = ^w;
        for (int i = 0; i < 5; i++) cycle(1'b1, w[19-4*i -: 4], 1'b0);
        for (int i = 0; i < hold_cycles; i++) cycle(1'b1, 4'($urandom), 1'b1);
        cycle(1'b0, 4'h0, 1'b0);
    endtask

    initial begin
        m_par = 1'b0;
        @(negedge clk);
        cycle(1'b0, 4'h0, 1'b0);
        cycle(1'b1, 4'h9, 1'b1);
        rst = 1'b0;
        send_word(20'hABCDE, 0);
        chk("plan_K1", 32'(bus.K1), 32'hABCDE);
        send_word(20'h12345, 0);
        chk("plan_K0", 32'(bus.K0), 32'h12345);
        chk("plan_S", 32'(bus.S), 32'd0);
        send_word(20'hFFFFF, 4);
        cycle(1'b1, 4'h7, 1'b0);
        cycle(1'b1, 4'h7, 1'b0);
        cycle(1'b1, 4'h7, 1'b0);
        rst = 1'b1;
        cycle(1'b0, 4'h0, 1'b0);
        rst = 1'b0;
        send_word(20'h00001, 0);
        chk("stale_K1", 32'(bus.K1), 32'h00001);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 4'(i % 2 == 0 ? 5 : 10), 1'b0);
            cycle(1'b0, 4'hF, 1'b0);
            cycle(1'b0, 4'hF, 1'b0);
        end
        chk("gap_K0", 32'(bus.K0), 32'h5A5A5);
`ifdef LOADER_PARITY_EN
        m_par = 1'b1;
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i == 4), 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        m_par = 1'b0;
        for (int i = 0; i < 5; i++) cycle(1'b1, 4'(i == 4), 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
`endif
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 59) == 0);
            m_par = 1'($urandom);
            cycle(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
